// File: rtl/icache_refill_ctrl.sv
// Instruction-cache miss refill and whole-cache invalidation controller.
// Fetches one aligned line per miss over a req/gnt/rvalid port and writes it through a one-cycle fill port.
module icache_refill_ctrl #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned ICLLEN = 128,
  parameter int unsigned ICLN   = 4,
  localparam int unsigned IDXB  = $clog2(ICLN),
  localparam int unsigned OFFB  = $clog2(ICLLEN/8),
  localparam int unsigned TAGB  = XLEN - IDXB - OFFB
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [XLEN-1:0]   addr,
  input  logic              miss,
  input  logic              flush,
  output logic              stall,
  output logic              mem_req,
  output logic [XLEN-1:0]   mem_addr,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [ICLLEN-1:0] mem_rdata,
  output logic              fill_we,
  output logic [IDXB-1:0]   fill_index,
  output logic [TAGB-1:0]   fill_tag,
  output logic [ICLLEN-1:0] fill_data,
  output logic              inv_we,
  output logic [IDXB-1:0]   inv_index,
  output logic              flush_done,
  output logic [31:0]       miss_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_FILL, S_FLUSH} state_e;

  localparam logic [XLEN-1:0] LINE_MASK = ~XLEN'(ICLLEN/8 - 1);
  localparam logic [IDXB-1:0] LAST_IDX  = IDXB'(ICLN - 1);

  state_e            state_q, state_d;
  logic [XLEN-1:0]   addr_q, addr_d;
  logic [ICLLEN-1:0] line_q, line_d;
  logic [IDXB-1:0]   cnt_q, cnt_d;
  logic [31:0]       miss_cnt_q, miss_cnt_d;
  logic              pend_q, pend_d;
  logic              mem_req_q, mem_req_d;
  logic              fill_we_q, fill_we_d;
  logic              inv_we_q, inv_we_d;
  logic [IDXB-1:0]   inv_index_q, inv_index_d;
  logic              flush_done_q, flush_done_d;

  // Next-state, datapath and next-output logic
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    line_d     = line_q;
    cnt_d      = cnt_q;
    miss_cnt_d = miss_cnt_q;
    pend_d     = pend_q;

    unique case (state_q)
      S_IDLE: begin
        if (flush) begin
          state_d = S_FLUSH;
        end else if (enable && miss) begin
          state_d = S_REQ;
          addr_d  = addr & LINE_MASK;
          if (miss_cnt_q != 32'hFFFF_FFFF) miss_cnt_d = miss_cnt_q + 32'd1;
        end
      end
      S_REQ: begin
        if (flush) pend_d = 1'b1;
        if (mem_gnt) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush) pend_d = 1'b1;
        if (mem_rvalid) begin
          line_d  = mem_rdata;
          state_d = S_FILL;
        end
      end
      S_FILL: begin
        // A flush seen in the fill cycle itself is folded into the pending request
        state_d = (pend_q || flush) ? S_FLUSH : S_IDLE;
      end
      S_FLUSH: begin
        if (cnt_q == LAST_IDX) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + IDXB'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_FLUSH && state_q != S_FLUSH) pend_d = 1'b0;

    mem_req_d    = (state_d == S_REQ);
    fill_we_d    = (state_d == S_FILL);
    inv_we_d     = (state_d == S_FLUSH);
    inv_index_d  = inv_we_d ? cnt_d : '0;
    flush_done_d = inv_we_d && (cnt_d == LAST_IDX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      line_q       <= '0;
      cnt_q        <= '0;
      miss_cnt_q   <= '0;
      pend_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      fill_we_q    <= 1'b0;
      inv_we_q     <= 1'b0;
      inv_index_q  <= '0;
      flush_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      line_q       <= line_d;
      cnt_q        <= cnt_d;
      miss_cnt_q   <= miss_cnt_d;
      pend_q       <= pend_d;
      mem_req_q    <= mem_req_d;
      fill_we_q    <= fill_we_d;
      inv_we_q     <= inv_we_d;
      inv_index_q  <= inv_index_d;
      flush_done_q <= flush_done_d;
    end
  end

  // Stall must react in the miss/flush request cycle itself, so it is combinational
  assign stall = !rst && ((state_q != S_IDLE) || flush || (enable && miss));

  assign mem_req    = mem_req_q;
  assign mem_addr   = mem_req_q ? addr_q : '0;
  assign fill_we    = fill_we_q;
  assign fill_index = fill_we_q ? addr_q[IDXB+OFFB-1:OFFB] : '0;
  assign fill_tag   = fill_we_q ? addr_q[XLEN-1:IDXB+OFFB] : '0;
  assign fill_data  = fill_we_q ? line_q : '0;
  assign inv_we     = inv_we_q;
  assign inv_index  = inv_index_q;
  assign flush_done = flush_done_q;
  assign miss_cnt   = miss_cnt_q;

endmodule

// File: doc/icache_refill_ctrl.md
Name: icache_refill_ctrl

Overview:
Miss-handling and maintenance controller for the instruction cache. It detects a fetch miss, stalls the fetch stage, and fetches the aligned line from the memory read port with a req/gnt/rvalid handshake. It then writes the line, tag and valid bit into the cache arrays through a one-cycle fill port. It also runs whole-cache invalidation (fence.i) with a sequential index counter. It sits between fetch, the icache arrays and the memory arbiter.

Parameters:
XLEN, 32, address width
ICLLEN, 128, cache line width in bits
ICLN, 4, number of cache lines (power of 2)
Derived: IDXB = clog2(ICLN); OFFB = clog2(ICLLEN/8); TAGB = XLEN-IDXB-OFFB

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
enable  in  1  fetch request valid
addr  in  XLEN  fetch address
miss  in  1  icache miss indication for addr
flush  in  1  invalidate-all request (level, sampled)
stall  out  1  hold fetch stage
mem_req  out  1  memory line read request
mem_addr  out  XLEN  line-aligned read address
mem_gnt  in  1  request accepted
mem_rvalid  in  1  read data valid
mem_rdata  in  ICLLEN  line data
fill_we  out  1  write one cache line (data, tag, valid=1)
fill_index  out  IDXB  line index for fill
fill_tag  out  TAGB  tag for fill
fill_data  out  ICLLEN  line data for fill
inv_we  out  1  clear valid bit of inv_index
inv_index  out  IDXB  line to invalidate
flush_done  out  1  one-cycle pulse at end of invalidation
miss_cnt  out  32  saturating count of refills started

Behaviour:
- Reset (async): state=IDLE. Latched addr, line buffer, flush counter, miss_cnt and pending-flush flag all clear to 0. mem_req, fill_we, inv_we and flush_done are 0. stall is forced 0 while rst=1.
- States: IDLE, REQ, WAIT, FILL, FLUSH.
- IDLE:
  - flush=1 -> FLUSH. Flush has priority over a simultaneous miss; the miss is re-evaluated after FLUSH.
  - else enable&miss=1 -> latch line address = addr with low OFFB bits zeroed, increment miss_cnt (saturates at 0xFFFF_FFFF), go to REQ.
- REQ:
  - mem_req=1 and mem_addr=latched address, held stable until mem_gnt.
  - mem_gnt=1 -> WAIT. A gnt in the same cycle as the REQ entry edge does not count; gnt is sampled only while in REQ.
- WAIT:
  - mem_req=0.
  - mem_rvalid=1 -> capture mem_rdata, go to FILL.
  - mem_rvalid in any other state is ignored.
- FILL (exactly 1 cycle): fill_we=1.
  - fill_index = latched[IDXB+OFFB-1:OFFB].
  - fill_tag = latched[XLEN-1:IDXB+OFFB].
  - fill_data = captured line.
  - Next state: FLUSH if the pending-flush flag is set, else IDLE.
- Flush arriving in REQ, WAIT or FILL sets the pending-flush flag. The refill always completes and is never aborted. The flag clears on entering FLUSH.
- FLUSH: counter runs 0..ICLN-1, one line per cycle.
  - inv_we=1 and inv_index=counter each cycle.
  - On counter=ICLN-1: flush_done=1, counter reset to 0, go to IDLE.
  - flush asserted during FLUSH is ignored (no restart). Total duration is exactly ICLN cycles.
- stall (combinational) = (state!=IDLE) | (state==IDLE & enable & miss) | (state==IDLE & flush).
  - stall deasserts the cycle after FILL or FLUSH completes.
  - In that cycle the cache re-looks-up addr and hits.
- fill_* and inv_* outputs are don't-care when their write enable is 0. They are driven to 0 for deterministic waveforms.
- Minimum miss penalty (gnt in the first REQ cycle, rvalid one cycle later): REQ(1) + WAIT(1) + FILL(1) = 3 stall cycles after the miss cycle.
- Reset asserted mid-refill or mid-flush returns immediately to IDLE. No fill or inv write occurs after the reset edge. A response arriving after reset is ignored.

Test Plan:
- Default params, enable=1, miss=1, addr=0x0000_1234; gnt 2 cycles after REQ entry, rvalid 3 cycles after gnt with data 0xDEADBEEF_0BADF00D_12345678_CAFEF00D -> mem_addr=0x0000_1230 held through REQ; one fill_we pulse with fill_index=3, fill_tag=0x48, matching fill_data; miss_cnt=1; stall low the cycle after FILL.
- mem_gnt=1 immediately and mem_rvalid one cycle later -> exactly 3 stall cycles after the miss cycle.
- flush=1 in IDLE with no miss -> inv_we for 4 cycles with inv_index 0,1,2,3; flush_done pulses on the index-3 cycle; stall high for 4 cycles plus the request cycle.
- flush pulsed during WAIT -> refill completes with a single fill_we, then FLUSH follows immediately; exactly one flush_done.
- flush and miss asserted together in IDLE -> FLUSH runs first, with no mem_req during it; afterwards the miss (if still asserted) starts a refill.
- rst asserted during WAIT, then rvalid arrives -> no fill_we; state IDLE; mem_req=0; miss_cnt=0; stall=0 while rst=1.
